// File: rtl/mux4x1_lanes.sv
// Serializes four stable 8-bit lanes into one byte stream at clk_4f in lane order 0..3,
// aligned by frame_start, with a strobe alignment monitor. Option: MUX4X1_ZERO_INVALID_EN.
module mux4x1_lanes (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_0ps,
  input  logic [7:0] data_1ps,
  input  logic [7:0] data_2ps,
  input  logic [7:0] data_3ps,
  input  logic       valid_0ps,
  input  logic       valid_1ps,
  input  logic       valid_2ps,
  input  logic       valid_3ps,
  input  logic       frame_start,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_idx,
  output logic       align_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] phase, phase_nxt;

  logic [7:0] hold_data [4];
  logic [3:0] hold_valid;

  logic [7:0] data_p0;
  logic       valid_p0;
  logic [1:0] idx_p0;
  logic       err_p0;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      phase <= 2'd0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    if (frame_start) begin
      state_nxt = RUN;
      phase_nxt = 2'd1;
    end else if (state == RUN) begin
      if (phase == 2'd0) begin
        state_nxt = IDLE;
        phase_nxt = 2'd0;
      end else begin
        phase_nxt = phase + 2'd1;
      end
    end else begin
      phase_nxt = 2'd0;
    end
  end

  // Lane 0 bypasses the holding registers so it appears one edge after the strobe.
  always_comb begin
    data_p0  = 8'h00;
    valid_p0 = 1'b0;
    idx_p0   = 2'd0;
    err_p0   = 1'b0;
    if (frame_start) begin
      data_p0  = data_0ps;
      valid_p0 = valid_0ps;
      err_p0   = (state == RUN) && (phase != 2'd0);
    end else if (state == RUN) begin
      if (phase == 2'd0) begin
        err_p0 = 1'b1;
      end else begin
        data_p0  = hold_data[phase];
        valid_p0 = hold_valid[phase];
        idx_p0   = phase;
      end
    end
`ifdef MUX4X1_ZERO_INVALID_EN
    if (!valid_p0) data_p0 = 8'h00;
`endif
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hold_data[i] <= 8'h00;
      hold_valid <= 4'b0000;
    end else if (frame_start) begin
      hold_data[0] <= data_0ps;
      hold_data[1] <= data_1ps;
      hold_data[2] <= data_2ps;
      hold_data[3] <= data_3ps;
      hold_valid   <= {valid_3ps, valid_2ps, valid_1ps, valid_0ps};
    end
  end

  // Output stage boundary: everything leaves on a register.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      lane_idx  <= 2'd0;
      align_err <= 1'b0;
    end else begin
      data_out  <= data_p0;
      valid_out <= valid_p0;
      lane_idx  <= idx_p0;
      align_err <= err_p0;
    end
  end

endmodule

// File: tb/tb_mux4x1_lanes.sv
// Bench for mux4x1_lanes: queue-based frame model checked every cycle, plus directed literal checks.
module tb_mux4x1_lanes;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] data_0ps, data_1ps, data_2ps, data_3ps;
  logic       valid_0ps, valid_1ps, valid_2ps, valid_3ps;
  logic       frame_start;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_idx;
  logic       align_err;

  int n_checks = 0;
  int n_fail   = 0;

  mux4x1_lanes dut (
    .clk_4f(clk_4f), .reset(reset),
    .data_0ps(data_0ps), .data_1ps(data_1ps), .data_2ps(data_2ps), .data_3ps(data_3ps),
    .valid_0ps(valid_0ps), .valid_1ps(valid_1ps), .valid_2ps(valid_2ps), .valid_3ps(valid_3ps),
    .frame_start(frame_start),
    .data_out(data_out), .valid_out(valid_out), .lane_idx(lane_idx), .align_err(align_err)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a frame is a list of slots still to be emitted; running means a frame has been seen.
  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [1:0] i;
  } slot_t;

  slot_t      pend[$];
  bit         running;
  logic [7:0] m_data;
  logic       m_valid;
  logic [1:0] m_idx;
  logic       m_err;

  function automatic logic [7:0] shown(input logic [7:0] d, input logic v);
`ifdef MUX4X1_ZERO_INVALID_EN
    return v ? d : 8'h00;
`else
    return d;
`endif
  endfunction

  always @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      pend.delete();
      running = 0;
      m_data = 0; m_valid = 0; m_idx = 0; m_err = 0;
    end else if (frame_start) begin
      m_err   = (pend.size() != 0);
      m_data  = shown(data_0ps, valid_0ps);
      m_valid = valid_0ps;
      m_idx   = 0;
      pend.delete();
      pend.push_back('{d: data_1ps, v: valid_1ps, i: 2'd1});
      pend.push_back('{d: data_2ps, v: valid_2ps, i: 2'd2});
      pend.push_back('{d: data_3ps, v: valid_3ps, i: 2'd3});
      running = 1;
    end else if (pend.size() > 0) begin
      slot_t s;
      s = pend.pop_front();
      m_data = shown(s.d, s.v); m_valid = s.v; m_idx = s.i; m_err = 0;
    end else if (running) begin
      m_data = 0; m_valid = 0; m_idx = 0; m_err = 1;
      running = 0;
    end else begin
      m_data = 0; m_valid = 0; m_idx = 0; m_err = 0;
    end
  end

  always @(negedge clk_4f) begin
    chk("model data_out", data_out, m_data);
    chk("model valid_out", valid_out, m_valid);
    chk("model lane_idx", lane_idx, m_idx);
    chk("model align_err", align_err, m_err);
  end

  task automatic tick();
    @(posedge clk_4f);
    @(negedge clk_4f);
  endtask

  task automatic set_lanes(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] d3, input logic [3:0] v);
    data_0ps = d0; data_1ps = d1; data_2ps = d2; data_3ps = d3;
    {valid_3ps, valid_2ps, valid_1ps, valid_0ps} = v;
  endtask

  task automatic expect_out(input string name, input logic [7:0] d, input logic v,
                            input logic [1:0] i, input logic e);
    chk({name, " data"}, data_out, d);
    chk({name, " valid"}, valid_out, v);
    chk({name, " idx"}, lane_idx, i);
    chk({name, " err"}, align_err, e);
  endtask

  initial begin
    logic [7:0] inv_exp;
    int cnt;
    reset = 1'b1;
    frame_start = 1'b0;
    set_lanes(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick();
    tick();
    expect_out("reset", 8'h00, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    expect_out("idle", 8'h00, 1'b0, 2'd0, 1'b0);

    // Steady frames
    for (int f = 0; f < 3; f++) begin
      set_lanes(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'hF);
      frame_start = 1'b1; tick(); expect_out("steady l0", 8'hAA, 1'b1, 2'd0, 1'b0);
      frame_start = 1'b0; tick(); expect_out("steady l1", 8'hBB, 1'b1, 2'd1, 1'b0);
      tick(); expect_out("steady l2", 8'hCC, 1'b1, 2'd2, 1'b0);
      tick(); expect_out("steady l3", 8'hDD, 1'b1, 2'd3, 1'b0);
    end

    // Strobe withheld
    tick(); expect_out("missing strobe", 8'h00, 1'b0, 2'd0, 1'b1);
    tick(); expect_out("idle after miss", 8'h00, 1'b0, 2'd0, 1'b0);
    tick(); expect_out("idle hold", 8'h00, 1'b0, 2'd0, 1'b0);
    set_lanes(8'h5A, 8'h6B, 8'h7C, 8'h8D, 4'hF);
    frame_start = 1'b1; tick(); expect_out("restart l0", 8'h5A, 1'b1, 2'd0, 1'b0);
    frame_start = 1'b0; tick(); tick(); tick();
    expect_out("restart l3", 8'h8D, 1'b1, 2'd3, 1'b0);

    // Lane 2 invalid
`ifdef MUX4X1_ZERO_INVALID_EN
    inv_exp = 8'h00;
`else
    inv_exp = 8'h55;
`endif
    set_lanes(8'h01, 8'h02, 8'h55, 8'h04, 4'b1011);
    frame_start = 1'b1; tick(); expect_out("inv l0", 8'h01, 1'b1, 2'd0, 1'b0);
    frame_start = 1'b0; tick();
    tick(); expect_out("inv l2", inv_exp, 1'b0, 2'd2, 1'b0);
    tick(); expect_out("inv l3", 8'h04, 1'b1, 2'd3, 1'b0);

    // Early strobe at phase 2
    set_lanes(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'hF);
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick(); expect_out("early pre", 8'hBB, 1'b1, 2'd1, 1'b0);
    set_lanes(8'h11, 8'h22, 8'h33, 8'h44, 4'hF);
    frame_start = 1'b1; tick(); expect_out("early l0", 8'h11, 1'b1, 2'd0, 1'b1);
    frame_start = 1'b0; tick(); expect_out("early l1", 8'h22, 1'b1, 2'd1, 1'b0);
    tick(); expect_out("early l2", 8'h33, 1'b1, 2'd2, 1'b0);
    tick(); expect_out("early l3", 8'h44, 1'b1, 2'd3, 1'b0);

    // Async reset mid-frame
    set_lanes(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'hF);
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick(); expect_out("pre reset", 8'hBB, 1'b1, 2'd1, 1'b0);
    #2 reset = 1'b1;
    #1 expect_out("async reset", 8'h00, 1'b0, 2'd0, 1'b0);
    tick(); reset = 1'b0;
    tick(); expect_out("post reset", 8'h00, 1'b0, 2'd0, 1'b0);
    set_lanes(8'h77, 8'h78, 8'h79, 8'h7A, 4'hF);
    frame_start = 1'b1; tick(); expect_out("post reset l0", 8'h77, 1'b1, 2'd0, 1'b0);
    frame_start = 1'b0; tick(); tick(); tick();

    // Back-to-back strobes
    set_lanes(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'hF);
    frame_start = 1'b1; tick(); expect_out("b2b first", 8'hAA, 1'b1, 2'd0, 1'b0);
    set_lanes(8'h61, 8'h62, 8'h63, 8'h64, 4'hF);
    tick(); expect_out("b2b second", 8'h61, 1'b1, 2'd0, 1'b1);
    frame_start = 1'b0; tick(); expect_out("b2b l1", 8'h62, 1'b1, 2'd1, 1'b0);
    tick(); tick();

    // Randomized traffic, mostly periodic with jitter, dropouts and rare resets
    cnt = 0;
    for (int n = 0; n < 600; n++) begin
      frame_start = 1'b0;
      if ((cnt == 0 && $urandom_range(0, 9) != 0) || $urandom_range(0, 19) == 0) begin
        set_lanes($urandom, $urandom, $urandom, $urandom, 4'($urandom));
        frame_start = 1'b1;
        cnt = 3;
      end else if (cnt > 0) begin
        cnt--;
      end
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt = 0;
      end else begin
        tick();
      end
    end
    frame_start = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4x1_lanes.md
# mux4x1_lanes

Downstream consumer of the four-lane clk_f flop stage in the PHY transmit path. Takes the four registered 8-bit lanes and their valids, which stay stable for four clk_4f cycles, and serializes them into one byte stream at clk_4f in lane order 0,1,2,3. A frame_start strobe aligns the block to the clk_f boundary. An alignment monitor flags missing or misplaced strobes.

## Interface
- No parameters; lane count is 4 and lane width is 8, both fixed.
- clk_4f  input  1  sole clock; 4x the clk_f rate, phase-locked to it
- reset  input  1  asynchronous, active-high; clears all state and outputs
- data_0ps, data_1ps, data_2ps, data_3ps  input  8 each  lane bytes, stable for 4 clk_4f cycles per clk_f period
- valid_0ps, valid_1ps, valid_2ps, valid_3ps  input  1 each  lane valids, same timing as the data
- frame_start  input  1  one-cycle pulse marking the first clk_4f cycle in which new lane words are stable
- data_out  output  8  serialized byte
- valid_out  output  1  valid of the lane currently on data_out
- lane_idx  output  2  lane number currently on data_out
- align_err  output  1  one-cycle pulse on an alignment fault

## Operation
- States: IDLE, RUN. Reset enters IDLE. The 2-bit phase counter is 0 in IDLE.
- Capture: on any edge with frame_start=1, the block does all of the following:
  - latches data/valid of lanes 1–3 into holding registers;
  - drives lane 0 directly to the output register (data_out<=data_0ps, valid_out<=valid_0ps, lane_idx<=0);
  - sets phase<=1 and goes to RUN.
- RUN, frame_start=0, phase 1..3: outputs the held lane[phase] with its valid, lane_idx<=phase, phase<=phase+1 (mod 4).
- RUN, frame_start=0, phase 0 (wrap with no strobe): the expected strobe is missing.
  - align_err<=1, valid_out<=0, data_out<=0, lane_idx<=0; go to IDLE.
- RUN, frame_start=1, phase 1..3 (early strobe): align_err<=1 and a normal capture. The remaining lanes of the old frame are dropped.
- RUN, frame_start=1, phase 0: normal capture, no error.
- IDLE, frame_start=0: data_out=0, valid_out=0, lane_idx=0, align_err=0.
- IDLE, frame_start=1: normal capture, no error.
- Invalid lanes still occupy their slot: lane_idx advances and valid_out=0 for that slot. data_out for such a slot follows Configuration.

## Timing
- Reset values: data_out=8'h00, valid_out=0, lane_idx=2'd0, align_err=0, state=IDLE, phase=0, holding registers=0.
- All outputs are registered on the clk_4f rising edge.
- Latency: strobe sampled at edge E0 puts lane 0 on the outputs after E0. Lanes 1, 2, 3 follow after E1, E2, E3.
- Steady state: strobe every 4th edge; one output byte per clk_4f; no bubbles.
- align_err is high for exactly one cycle, after the offending edge.
- Reset asserted mid-frame clears outputs immediately (asynchronous). After release the block waits in IDLE for the next strobe; no error is raised.

## Configuration
- MUX4X1_ZERO_INVALID_EN defined: data_out is forced to 8'h00 on every cycle where valid_out=0, including invalid-lane slots.
- Undefined: invalid-lane slots carry the lane's raw byte on data_out. In IDLE and on the missing-strobe cycle, data_out is still 8'h00.

## Test plan
- Reset then steady frames: lanes AA/BB/CC/DD all valid, strobe every 4 cycles.
  - data_out = AA,BB,CC,DD repeating; lane_idx 0,1,2,3; valid_out=1 continuously; align_err never asserts.
- Lane 2 invalid with data 0x55.
  - Slot 2: valid_out=0 and lane_idx=2.
  - data_out=0x00 with MUX4X1_ZERO_INVALID_EN defined, 0x55 without it.
- Strobe withheld after one frame.
  - After DD: one cycle of align_err=1 with valid_out=0 and data_out=0, then the block holds in IDLE.
  - The next strobe restarts output at lane 0 with no error.
- Early strobe at phase 2 (right after BB is output) carrying new lanes 11/22/33/44.
  - align_err=1 together with data_out=11; then 22,33,44. Old CC/DD never appear.
- Async reset pulsed mid-frame (after BB): outputs go to zero without a clock edge.
  - After release: no align_err; the next strobe yields the new lane 0 one cycle later.
- Back-to-back strobes on consecutive cycles.
  - align_err on the second; output restarts at that frame's lane 0.
